// File: rtl/toy_fetch_credit_mgr.sv
// Halfword credit manager between fetch request generator and instruction buffer.
// Optional sticky error tracking is enabled by defining TOY_FETCH_CREDIT_ERR_EN.
module toy_fetch_credit_mgr #(
    parameter int unsigned DEPTH_HW   = 128,
    parameter int unsigned LINE_HW    = 8,
    parameter int unsigned RD_CH      = 4,
    parameter int unsigned MAX_OUT    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    output logic                              req_vld,
    input  logic                              req_rdy,
    input  logic [ADDR_WIDTH-1:0]             fetch_addr,
    input  logic                              resp_vld,
    output logic                              resp_drop,
    input  logic [RD_CH-1:0]                  ack_vld,
    input  logic [RD_CH-1:0]                  ack_rdy,
    input  logic [RD_CH*INST_WIDTH-1:0]       ack_pld,
    output logic [$clog2(DEPTH_HW):0]         credit_free,
    output logic [$clog2(MAX_OUT):0]          out_cnt,
    output logic                              err
);

    localparam int unsigned CW = $clog2(DEPTH_HW) + 1;
    localparam int unsigned AW = CW + 1;
    localparam int unsigned OW = $clog2(MAX_OUT) + 1;
    localparam int unsigned LB = $clog2(LINE_HW);

    logic [CW-1:0] cnt_q, cnt_n;
    logic [OW-1:0] out_q, out_n;
    logic [OW-1:0] drop_q, drop_n;
    logic [LB-1:0] off;
    logic [AW-1:0] req_hw;
    logic [AW-1:0] sub;
    logic [AW-1:0] sum;
    logic [AW-1:0] diff;
    logic          issue;
    logic          cnt_err;
    logic          out_err;
    logic          unused_bits;

    // Request size: remainder of the line from the halfword offset.
    assign off    = fetch_addr[LB:1];
    assign req_hw = AW'(LINE_HW) - AW'(off);

    assign credit_free = CW'(DEPTH_HW) - cnt_q;
    assign out_cnt     = out_q;
    assign req_vld     = rst_n & ~clear & (AW'(credit_free) >= req_hw)
                         & (out_q < OW'(MAX_OUT));
    assign issue       = req_vld & req_rdy;
    assign resp_drop   = resp_vld & (drop_q != '0);

    // Halfwords released by all firing consume channels (32-bit insts take two).
    always_comb begin
        sub = '0;
        for (int unsigned i = 0; i < RD_CH; i++) begin
            if (ack_vld[i] && ack_rdy[i]) begin
                sub = sub + ((ack_pld[i*INST_WIDTH +: 2] == 2'b11) ? AW'(2) : AW'(1));
            end
        end
    end

    // Next-state for credit, outstanding and stale-response counters.
    always_comb begin
        cnt_n   = cnt_q;
        out_n   = out_q;
        drop_n  = drop_q;
        cnt_err = 1'b0;
        out_err = 1'b0;
        sum     = AW'(cnt_q) + (issue ? req_hw : AW'(0));
        diff    = sum - sub;

        if (clear) begin
            cnt_n = '0;
        end else if (sub > sum) begin
            cnt_n   = '0;
            cnt_err = 1'b1;
        end else if (diff > AW'(DEPTH_HW)) begin
            cnt_n   = CW'(DEPTH_HW);
            cnt_err = 1'b1;
        end else begin
            cnt_n = CW'(diff);
        end

        if (resp_vld && (out_q == '0)) begin
            out_err = 1'b1;
        end
        if (issue && !resp_vld) begin
            out_n = out_q + OW'(1);
        end else if (!issue && resp_vld && (out_q != '0)) begin
            out_n = out_q - OW'(1);
        end

        // On flush every request still in flight after this cycle turns stale.
        if (clear) begin
            drop_n = out_n;
        end else if (resp_drop) begin
            drop_n = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_n;
            out_q  <= out_n;
            drop_q <= drop_n;
        end
    end

`ifdef TOY_FETCH_CREDIT_ERR_EN
    logic err_q;

    // Sticky; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | cnt_err | out_err;
        end
    end

    assign err         = err_q;
    assign unused_bits = ^{fetch_addr, ack_pld};
`else
    assign err         = 1'b0;
    assign unused_bits = ^{fetch_addr, ack_pld, cnt_err, out_err};
`endif

endmodule
